// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory,
// with alignment/range checking and read-modify-write for sub-word stores.
`default_nettype none

module load_store_unit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  output logic        MemWrite,
  output logic        MemRead
);

  localparam logic [31:0] c_DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic [31:0] w_idx;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge;

  assign ReqReady = (r_state == IDLE);

  assign w_idx = {2'b00, ReqAddr[31:2]};
  assign w_err = (ReqSize == 2'b11)
               | ((ReqSize == 2'b01) & ReqAddr[0])
               | ((ReqSize == 2'b10) & (|ReqAddr[1:0]))
               | (w_idx >= c_DEPTH);

  always_comb begin
    w_byte      = MemReadData[{r_lane, 3'b000} +: 8];
    w_half      = r_lane[1] ? MemReadData[31:16] : MemReadData[15:0];
    w_load_data = MemReadData;
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = MemReadData;
    endcase
  end

  // Sub-word store: replace only the addressed lane(s) of the word just read.
  always_comb begin
    w_merge = MemReadData;
    if (r_size == 2'b00) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_lane[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      RespValid    <= 1'b0;
      RespRData    <= 32'h0;
      RespError    <= 1'b0;
      MemAddress   <= 32'h0;
      MemWriteData <= 32'h0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ReqValid) begin
            r_write  <= ReqWrite;
            r_size   <= ReqSize;
            r_signed <= ReqSigned;
            r_lane   <= ReqAddr[1:0];
            r_wdata  <= ReqWData[15:0];
            if (w_err) begin
              r_state   <= RESP;
              RespValid <= 1'b1;
              RespError <= 1'b1;
              RespRData <= 32'h0;
            end else if (ReqWrite && (ReqSize == 2'b10)) begin
              r_state      <= WR;
              MemWrite     <= 1'b1;
              MemAddress   <= w_idx;
              MemWriteData <= ReqWData;
            end else begin
              r_state    <= RD;
              MemRead    <= 1'b1;
              MemAddress <= w_idx;
            end
          end
        end
        RD: begin
          MemRead <= 1'b0;
          if (r_write) begin
            r_state      <= WR;
            MemWrite     <= 1'b1;
            MemWriteData <= w_merge;
          end else begin
            r_state    <= RESP;
            MemAddress <= 32'h0;
            RespValid  <= 1'b1;
            RespRData  <= w_load_data;
          end
        end
        WR: begin
          r_state      <= RESP;
          MemWrite     <= 1'b0;
          MemWriteData <= 32'h0;
          MemAddress   <= 32'h0;
          RespValid    <= 1'b1;
          RespRData    <= 32'h0;
          RespError    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          RespValid <= 1'b0;
          RespRData <= 32'h0;
          RespError <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_DEPTH, default 256, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ReqValid  input  1  CPU access request present.
REQ-005 ReqReady  output  1  unit can accept a request this cycle.
REQ-006 ReqWrite  input  1  1 = store, 0 = load.
REQ-007 ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 ReqSigned  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-009 ReqAddr  input  32  byte address.
REQ-010 ReqWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 RespValid  output  1  one-cycle completion pulse.
REQ-012 RespRData  output  32  load result, valid with RespValid.
REQ-013 RespError  output  1  access rejected, valid with RespValid.
REQ-014 MemAddress  output  32  word index to data memory (ReqAddr >> 2).
REQ-015 MemWriteData  output  32  word written to data memory.
REQ-016 MemReadData  input  32  combinational read data from data memory.
REQ-017 MemWrite  output  1  data memory write enable.
REQ-018 MemRead  output  1  data memory read enable.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, RESP; ReqReady SHALL be 1 only in IDLE.
REQ-020 Request SHALL be accepted on a rising edge with ReqValid=1 in IDLE; all Req* fields registered then; ReqValid outside IDLE SHALL be ignored.
REQ-021 Error check at acceptance: ReqSize=11, half with ReqAddr[0]=1, word with ReqAddr[1:0]!=0, or (ReqAddr>>2) >= MEM_DEPTH SHALL go IDLE->RESP with RespError=1, RespRData=0, no MemRead/MemWrite ever asserted.
REQ-022 Load: IDLE->RD->RESP->IDLE; in RD MemRead=1, MemReadData captured at end of RD; RespValid at acceptance+2 cycles.
REQ-023 Word store: IDLE->WR->RESP->IDLE; MemWrite=1 for exactly the one WR cycle with MemWriteData=ReqWData; RespValid at acceptance+2.
REQ-024 Byte/half store (read-modify-write): IDLE->RD->WR->RESP->IDLE; RD captures word, WR writes captured word with only the addressed lane(s) replaced; RespValid at acceptance+3.
REQ-025 Lane mapping little-endian: byte k = bits [8k+7:8k], k=ReqAddr[1:0]; half at ReqAddr[1] selects [31:16] or [15:0].
REQ-026 Loads: selected byte/half extended per ReqSigned; word loads ignore ReqSigned.
REQ-027 RespValid SHALL be high exactly one cycle (RESP); no backpressure; RespRData=0 and RespError=0 for stores without error.
REQ-028 MemRead SHALL be 1 only in RD, MemWrite only in WR, never both; MemAddress SHALL hold the registered word index in RD/WR and 0 otherwise; MemWriteData 0 outside WR.
REQ-029 Next request SHALL be acceptable the cycle after RESP.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and all outputs to 0 except ReqReady, which SHALL be 1 (0 while rst_n=0 is not required; ReqReady=1 from first edge after release).
REQ-031 Reset in RD SHALL abandon the operation with no memory write; reset in WR SHALL deassert MemWrite immediately; no RespValid for the aborted request.

Verification
REQ-032 sw 0x11223344 @0x10, then lw @0x10 -> MemWrite one cycle with MemAddress=4; load RespRData=0x11223344 at acceptance+2.
REQ-033 sb ReqWData=0x000000AB @0x11 over word 0x11223344 -> RD then WR with MemWriteData=0x1122AB44, RespValid at +3; lb @0x11 -> 0xFFFFFFAB; lbu -> 0x000000AB.
REQ-034 Word 0x80001234 @0x10: lh @0x12 -> 0xFFFF8000; lhu @0x12 -> 0x00008000; lh @0x10 -> 0x00001234.
REQ-035 lw @0x13, lh @0x11, ReqSize=11, lw @0x400 -> RespError=1 at +1, RespRData=0, MemRead/MemWrite never 1.
REQ-036 sh @0x20 with rst_n pulsed low during RD -> outputs 0 immediately, no MemWrite, no RespValid, ReqReady=1 after release, word 0x8 unchanged.
REQ-037 ReqValid held high for two loads -> second accepted only in cycle after first RESP; changing Req* fields while busy does not affect the in-flight access.
